// File: rtl/gray_bin_conv.sv
// Two-stage streaming Gray/binary converter with valid/ready handshakes on both sides.
// G2B beats are compared against the previous G2B code; jumps of two or more bits are counted.
module gray_bin_conv #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_in_mode,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_mode,
    output logic             o_out_adj_err,
    output logic [CNT_W-1:0] o_err_cnt
);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_data;
    logic             r_s1_mode;
    logic             r_s1_adj;

    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_data;
    logic             r_s2_mode;
    logic             r_s2_adj;

    logic [WIDTH-1:0] r_prev_g;
    logic             r_prev_v;
    logic [CNT_W-1:0] r_err_cnt;

    logic             w_s2_load;
    logic             w_accept;
    logic             w_deliver;
    logic [WIDTH-1:0] w_diff;
    logic             w_far;
    logic             w_adj;
    logic [WIDTH-1:0] w_g2b;
    logic [WIDTH-1:0] w_b2g;
    logic [WIDTH-1:0] w_conv;

    assign w_s2_load  = !r_s2_valid || i_out_ready;
    assign o_in_ready = !r_s1_valid || w_s2_load;
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_deliver  = r_s2_valid && i_out_ready;

    // Clearing the lowest set bit leaves something non-zero only when two or more bits differ.
    assign w_diff = i_in_data ^ r_prev_g;
    assign w_far  = |(w_diff & (w_diff - WIDTH'(1)));
    assign w_adj  = !i_in_mode && r_prev_v && w_far;

    always_comb begin
        w_g2b = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_g2b[i] = ^(r_s1_data >> i);
        end
    end

    assign w_b2g  = r_s1_data ^ (r_s1_data >> 1);
    assign w_conv = r_s1_mode ? w_b2g : w_g2b;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_mode  <= 1'b0;
            r_s1_adj   <= 1'b0;
        end else if (o_in_ready) begin
            r_s1_valid <= i_in_valid;
            if (w_accept) begin
                r_s1_data <= i_in_data;
                r_s1_mode <= i_in_mode;
                r_s1_adj  <= w_adj;
            end
        end
    end

    // S2 keeps its last contents when a bubble moves in, so idle outputs do not toggle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_mode  <= 1'b0;
            r_s2_adj   <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_conv;
                r_s2_mode <= r_s1_mode;
                r_s2_adj  <= r_s1_adj;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev_g <= '0;
            r_prev_v <= 1'b0;
        end else if (w_accept && !i_in_mode) begin
            r_prev_g <= i_in_data;
            r_prev_v <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err_cnt <= '0;
        end else if (w_deliver && r_s2_adj && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign o_out_valid   = r_s2_valid;
    assign o_out_data    = r_s2_data;
    assign o_out_mode    = r_s2_mode;
    assign o_out_adj_err = r_s2_adj;
    assign o_err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_gray_bin_conv.sv
// Bench for gray_bin_conv: directed scenarios plus a random phase, checked every cycle
// against a queue-based model of in-flight beats.
module tb_gray_bin_conv;

    localparam int W = 4;
    localparam int C = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_mode;
    logic         out_adj_err;
    logic [C-1:0] err_cnt;

    gray_bin_conv #(.WIDTH(W), .CNT_W(C)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_data    (in_data),
        .i_in_mode    (in_mode),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_data   (out_data),
        .o_out_mode   (out_mode),
        .o_out_adj_err(out_adj_err),
        .o_err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         m;
        logic         f;
        int           age;
    } beat_t;

    beat_t        q[$];
    logic [W-1:0] m_prev;
    logic         m_prev_v;
    int           m_cnt;
    logic         last_acc;
    int           n_cmp;
    int           n_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Gray-to-binary by search: the binary value whose Gray encoding matches.
    function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = '0;
        for (int v = 0; v < (1 << W); v++) begin
            if (W'(v ^ (v >> 1)) == g) b = W'(v);
        end
        return b;
    endfunction

    task automatic tick();
        logic  exp_ready;
        logic  exp_valid;
        logic  acc;
        logic  dlv;
        beat_t nb;
        #1;
        exp_ready = (q.size() < 2) || out_ready;
        exp_valid = (q.size() > 0) && (q[0].age >= 1);
        if (!rst) begin
            chk("in_ready", 32'(in_ready), 32'(exp_ready));
            chk("out_valid", 32'(out_valid), 32'(exp_valid));
            chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
            if (exp_valid) begin
                chk("out_data", 32'(out_data), 32'(q[0].d));
                chk("out_mode", 32'(out_mode), 32'(q[0].m));
                chk("out_adj_err", 32'(out_adj_err), 32'(q[0].f));
            end
        end
        acc = in_valid && exp_ready;
        dlv = exp_valid && out_ready;
        @(posedge clk);
        last_acc = 1'b0;
        if (rst) begin
            q.delete();
            m_prev   = '0;
            m_prev_v = 1'b0;
            m_cnt    = 0;
        end else begin
            if (dlv) begin
                if (q[0].f && m_cnt < (1 << C) - 1) m_cnt++;
                void'(q.pop_front());
            end
            foreach (q[i]) q[i].age++;
            if (acc) begin
                nb.d   = in_mode ? (in_data ^ (in_data >> 1)) : ref_g2b(in_data);
                nb.m   = in_mode;
                nb.f   = !in_mode && m_prev_v && ($countones(in_data ^ m_prev) >= 2);
                nb.age = 0;
                q.push_back(nb);
                if (!in_mode) begin
                    m_prev   = in_data;
                    m_prev_v = 1'b1;
                end
                last_acc = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] d, input logic m);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (last_acc) break;
        end
        chk("send_timeout", 32'(last_acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [W-1:0] bp_beats[4];
    int           idx;
    logic [W-1:0] g;

    initial begin
        n_cmp = 0; n_bad = 0; m_cnt = 0; m_prev = '0; m_prev_v = 1'b0; last_acc = 1'b0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_mode", 32'(out_mode), 32'd0);
        chk("rst_out_adj", 32'(out_adj_err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Directed single conversions
        out_ready = 1'b1;
        send(4'b1011, 1'b0);
        chk("g2b_not_yet", 32'(out_valid), 32'd0);
        idle(1);
        chk("g2b_valid", 32'(out_valid), 32'd1);
        chk("g2b_1011", 32'(out_data), 32'b1101);
        chk("g2b_adj", 32'(out_adj_err), 32'd0);
        idle(1);
        send(4'b1101, 1'b1);
        idle(1);
        chk("b2g_1101", 32'(out_data), 32'b1011);
        idle(1);

        // Exhaustive sweep in both modes, then explicit round trip
        for (int v = 0; v < 16; v++) send(W'(v), 1'b1);
        for (int v = 0; v < 16; v++) send(W'(v), 1'b0);
        idle(3);
        for (int v = 0; v < 16; v++) begin
            g = W'(v);
            g = g ^ (g >> 1);
            send(g, 1'b0);
            idle(1);
            chk("round_trip", 32'(out_data), 32'(v));
        end
        idle(2);

        // Adjacency sequence with a B2G beat in the middle
        do_reset();
        send(4'b0000, 1'b0);
        send(4'b0001, 1'b0);
        send(4'b1111, 1'b1);
        send(4'b0001, 1'b0);
        send(4'b0111, 1'b0);
        send(4'b0101, 1'b0);
        idle(3);
        chk("adj_err_cnt", 32'(err_cnt), 32'd1);

        // Backpressure: four beats offered against a stalled sink
        bp_beats[0] = 4'b0010; bp_beats[1] = 4'b0110;
        bp_beats[2] = 4'b0111; bp_beats[3] = 4'b0101;
        out_ready = 1'b0;
        idx = 0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_data  = bp_beats[idx];
            in_mode  = 1'b0;
            tick();
            if (last_acc) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 20 && idx < 4; k++) begin
            in_data = bp_beats[idx];
            tick();
            if (last_acc) idx++;
        end
        chk("bp_all_sent", 32'(idx), 32'd4);
        idle(4);

        // Reset with both stages full
        out_ready = 1'b0;
        send(4'b0011, 1'b0);
        send(4'b1100, 1'b0);
        chk("mid_full", 32'(in_ready), 32'd0);
        do_reset();
        #1;
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_err_cnt", 32'(err_cnt), 32'd0);
        chk("mid_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
        send(4'b1111, 1'b0);
        idle(1);
        chk("mid_first_flag", 32'(out_adj_err), 32'd0);
        idle(2);

        // Saturation of the error counter
        for (int i = 0; i < 302; i++) send((i % 2) != 0 ? 4'b0011 : 4'b0000, 1'b0);
        idle(3);
        chk("sat_255", 32'(err_cnt), 32'd255);
        send(4'b1100, 1'b0);
        idle(3);
        chk("sat_hold", 32'(err_cnt), 32'd255);

        // Random traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = W'($urandom);
                in_mode  = ($urandom_range(0, 2) == 0);
            end
            tick();
        end
        rst = 1'b0;
        out_ready = 1'b1;
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
